// File: rtl/read_pointer_fwft.sv
// Read-domain side of an async FIFO: binary/Gray read pointers, empty detection,
// storage level, and a one-entry first-word-fall-through output register.
module read_pointer_fwft #(
  parameter int DW    = 8,
  parameter int ASIZE = 3
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   sync_wptr_gray,
  input  logic [DW-1:0]    mem_rdata,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr_bin,
  output logic [ASIZE:0]   rptr_gray,
  output logic             empty,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [ASIZE:0]   rd_level
);

  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic           pop;
  logic [ASIZE:0] rptr_bin_nxt;
  logic [ASIZE:0] wptr_bin;

  always_comb begin
    empty        = (rptr_gray == sync_wptr_gray);
    pop          = ~empty & (~dout_valid | dout_ready);
    rptr_bin_nxt = rptr_bin + PTR_ONE;
    wptr_bin     = gray2bin(sync_wptr_gray);
  end

  assign raddr = rptr_bin[ASIZE-1:0];

  // A pop and a handshake transfer in the same edge replace the word in place.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_bin   <= '0;
      rptr_gray  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_level   <= '0;
    end else begin
      if (pop) begin
        dout       <= mem_rdata;
        dout_valid <= 1'b1;
        rptr_bin   <= rptr_bin_nxt;
        rptr_gray  <= bin2gray(rptr_bin_nxt);
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      rd_level <= wptr_bin - rptr_bin;
    end
  end

endmodule
